// File: rtl/muldiv_div_seq_if.sv
// Request/response bundle between EXE and the iterative divide sequencer.
interface muldiv_div_seq_if #(parameter int XLEN = 32);
  logic            div_req_i;
  logic [1:0]      div_op_i;
  logic [XLEN-1:0] operand_1_i;
  logic [XLEN-1:0] operand_2_i;
  logic            kill_i;
  logic            stall_o;
  logic            res_valid_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output div_req_i, div_op_i, operand_1_i, operand_2_i, kill_i,
    input  stall_o, res_valid_o, result_o
  );

  modport slave (
    input  div_req_i, div_op_i, operand_1_i, operand_2_i, kill_i,
    output stall_o, res_valid_o, result_o
  );
endinterface

// File: rtl/muldiv_div_seq.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU; stalls EXE while iterating
// and pulses res_valid_o for one cycle with the sign-corrected result.
module muldiv_div_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic           clk,
  input  logic           rst_n,
  muldiv_div_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op;
  logic             neg_q, neg_r;
  logic [XLEN-1:0]  rem, quo, dvs, res;
  logic             stall, res_valid;

  logic            signed_op, s1, s2, div_zero, ovf, accept;
  logic [XLEN-1:0] abs1, abs2;
  logic [XLEN:0]   r_sh, diff;
  logic [XLEN-1:0] rem_step, quo_step, fin;

  assign signed_op = ~bus.div_op_i[0];
  assign s1        = signed_op & bus.operand_1_i[XLEN-1];
  assign s2        = signed_op & bus.operand_2_i[XLEN-1];
  assign abs1      = s1 ? -bus.operand_1_i : bus.operand_1_i;
  assign abs2      = s2 ? -bus.operand_2_i : bus.operand_2_i;
  assign div_zero  = (bus.operand_2_i == '0);
  assign ovf       = signed_op & (bus.operand_1_i == {1'b1, {(XLEN-1){1'b0}}})
                   & (bus.operand_2_i == '1);
  assign accept    = (state == IDLE) & bus.div_req_i & ~bus.kill_i;

  // One restoring step; XLEN+1 bits so the trial subtract's sign is visible.
  assign r_sh     = {rem, quo[XLEN-1]};
  assign diff     = r_sh - {1'b0, dvs};
  assign rem_step = diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_step = {quo[XLEN-2:0], ~diff[XLEN]};
  // Final fix-up applied to the last step so result_o is ready when DONE begins.
  assign fin      = op[1] ? (neg_r ? -rem_step : rem_step)
                          : (neg_q ? -quo_step : quo_step);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    stall     = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: if (accept) begin
        stall   = 1'b1;
        state_n = (div_zero | ovf) ? DONE : CALC;
      end
      CALC: begin
        stall = ~bus.kill_i;
        if (bus.kill_i)    state_n = IDLE;
        else if (cnt == 0) state_n = DONE;
      end
      DONE: begin
        res_valid = ~bus.kill_i;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      op    <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      res   <= '0;
    end else if (accept) begin
      op    <= bus.div_op_i;
      neg_q <= s1 ^ s2;
      neg_r <= s1;
      dvs   <= abs2;
      rem   <= '0;
      quo   <= abs1;
      cnt   <= CNT_W'(XLEN-1);
      if (div_zero)
        res <= bus.div_op_i[1] ? bus.operand_1_i : '1;
      else if (ovf)
        res <= bus.div_op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end else if ((state == CALC) && !bus.kill_i) begin
      rem <= rem_step;
      quo <= quo_step;
      cnt <= cnt - 1'b1;
      if (cnt == 0) res <= fin;
    end
  end

  assign bus.stall_o     = stall;
  assign bus.res_valid_o = res_valid;
  assign bus.result_o    = res;

endmodule

// File: tb/tb_muldiv_div_seq.sv
// Directed bench for muldiv_div_seq: arithmetic, special cases, kill and reset.
module tb_muldiv_div_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  muldiv_div_seq_if #(.XLEN(32)) bus ();
  muldiv_div_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one request starting in the current cycle (C0) and checks the
  // cycle on which res_valid_o appears, the stall count and the result.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int n;
    int stalls;
    bit got;
    bus.div_req_i = 1'b1; bus.div_op_i = op;
    bus.operand_1_i = a;  bus.operand_2_i = b;
    @(negedge clk);
    chk({tag, " stall_c0"}, 32'(bus.stall_o), 32'd1);
    @(posedge clk); #1;
    bus.div_req_i = 1'b0;
    bus.operand_1_i = $urandom; bus.operand_2_i = $urandom;
    n = 1; stalls = 0; got = 1'b0;
    while (n <= 40 && !got) begin
      @(negedge clk);
      if (bus.res_valid_o) got = 1'b1;
      else begin
        if (bus.stall_o) stalls++;
        n++;
      end
    end
    chk({tag, " latency"}, 32'(n), 32'(exp_lat));
    chk({tag, " stall_cycles"}, 32'(stalls), 32'(exp_lat - 1));
    chk({tag, " result"}, bus.result_o, exp_res);
    chk({tag, " stall_done"}, 32'(bus.stall_o), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int pulses;
    bus.div_req_i = 1'b0; bus.div_op_i = DIVU; bus.kill_i = 1'b0;
    bus.operand_1_i = '0; bus.operand_2_i = '0;

    #3;
    chk("rst stall", 32'(bus.stall_o), 32'd0);
    chk("rst valid", 32'(bus.res_valid_o), 32'd0);
    chk("rst result", bus.result_o, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("divu 100/7", DIVU, 32'd100, 32'd7, 32'd14, 33);
    do_op("remu 100/7", REMU, 32'd100, 32'd7, 32'd2, 33);
    do_op("div -100/7", DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 33);
    do_op("rem -100/7", REM, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 33);
    do_op("div 100/-7", DIV, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 33);
    do_op("rem 100/-7", REM, 32'd100, 32'hFFFFFFF9, 32'd2, 33);
    do_op("div -100/-7", DIV, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 33);
    do_op("rem -100/-7", REM, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 33);
    do_op("divu max/1", DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 33);
    do_op("remu min/-1", REMU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
    do_op("divu min/-1", DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33);

    do_op("divu /0", DIVU, 32'h1234, 32'd0, 32'hFFFFFFFF, 1);
    do_op("div /0", DIV, 32'h1234, 32'd0, 32'hFFFFFFFF, 1);
    do_op("remu /0", REMU, 32'h1234, 32'd0, 32'h1234, 1);
    do_op("rem /0", REM, 32'h1234, 32'd0, 32'h1234, 1);
    do_op("div ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    do_op("rem ovf", REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);

    // Kill together with a request in IDLE: nothing is accepted.
    bus.div_req_i = 1'b1; bus.kill_i = 1'b1; bus.div_op_i = DIVU;
    bus.operand_1_i = 32'd100; bus.operand_2_i = 32'd7;
    @(negedge clk);
    chk("idle kill stall", 32'(bus.stall_o), 32'd0);
    @(posedge clk); #1 bus.div_req_i = 1'b0; bus.kill_i = 1'b0;
    @(negedge clk);
    chk("idle kill no stall", 32'(bus.stall_o), 32'd0);
    @(posedge clk); #1;

    // Kill at C10 of DIVU 100/7, then DIVU 9/3 accepted at C11.
    bus.div_req_i = 1'b1; bus.div_op_i = DIVU;
    bus.operand_1_i = 32'd100; bus.operand_2_i = 32'd7;
    @(posedge clk); #1 bus.div_req_i = 1'b0;
    pulses = 0;
    repeat (9) begin
      @(negedge clk); if (bus.res_valid_o) pulses++;
      @(posedge clk); #1;
    end
    bus.kill_i = 1'b1;
    @(negedge clk);
    chk("kill stall c10", 32'(bus.stall_o), 32'd0);
    if (bus.res_valid_o) pulses++;
    @(posedge clk); #1 bus.kill_i = 1'b0;
    chk("kill no pulse", 32'(pulses), 32'd0);
    do_op("divu 9/3 after kill", DIVU, 32'd9, 32'd3, 32'd3, 33);

    // Asynchronous reset in the middle of CALC.
    bus.div_req_i = 1'b1; bus.div_op_i = DIVU;
    bus.operand_1_i = 32'd1000; bus.operand_2_i = 32'd10;
    @(posedge clk); #1 bus.div_req_i = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst stall", 32'(bus.stall_o), 32'd0);
    chk("async rst valid", 32'(bus.res_valid_o), 32'd0);
    chk("async rst result", bus.result_o, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk); if (bus.res_valid_o || bus.stall_o) pulses++;
    end
    chk("post rst quiet", 32'(pulses), 32'd0);
    @(posedge clk); #1;

    // Back-to-back: each request starts the cycle after the previous DONE.
    do_op("b2b div", DIV, 32'd1000, 32'hFFFFFFF6, 32'hFFFFFF9C, 33);
    do_op("b2b remu", REMU, 32'd1001, 32'd10, 32'd1, 33);
    do_op("b2b rem /0", REM, 32'hDEADBEEF, 32'd0, 32'hDEADBEEF, 1);
    do_op("b2b divu", DIVU, 32'd12345678, 32'd1000, 32'd12345, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
